// File: rtl/audio_pkg.sv
// audio_pkg: shared definitions for the audio tone generator.
//   SAMPLE_W      width of the signed sample output
//   NOTE_W        width of a note half-period
//   audio_state_t FSM state encoding (IDLE, PLAY)
//   NOTE_HALF     half-periods in 50 MHz clock cycles, C4 (sel 1) .. D5 (sel 15)
//   half_period() scaled half-period, never below 1
package audio_pkg;

   localparam int unsigned SAMPLE_W = 6;
   localparam int unsigned NOTE_W   = 17;

   typedef enum logic {
      IDLE,
      PLAY
   } audio_state_t;

   localparam logic [NOTE_W-1:0] NOTE_HALF [0:15] = '{
      17'd0,       // 0: stop, unused
      17'd95556,   // C4
      17'd90194,   // C#4
      17'd85131,   // D4
      17'd80353,   // D#4
      17'd75843,   // E4
      17'd71586,   // F4
      17'd67569,   // F#4
      17'd63776,   // G4
      17'd60197,   // G#4
      17'd56818,   // A4
      17'd53629,   // A#4
      17'd50619,   // B4
      17'd47778,   // C5
      17'd45097,   // C#5
      17'd42566    // D5
   };

   function automatic logic [NOTE_W-1:0] half_period(input logic [3:0] sel,
                                                     input int unsigned shift);
      logic [NOTE_W-1:0] h;
      h = NOTE_HALF[sel] >> shift;
      if (h == '0) begin
         h = NOTE_W'(1);
      end
      return h;
   endfunction

endpackage

// File: rtl/audio_tone_gen_pwm.sv
// audio_pwm_mod: free-running 5-bit PWM counter and volume compare.
//   clk, reset  clock, synchronous active-low reset
//   en          output enable (high while playing)
//   sq          square-wave polarity
//   vol_q       registered volume 0..31
//   audio_pwm   PWM bit: high while sq and counter below volume
module audio_pwm_mod (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       sq,
   input  logic [4:0] vol_q,
   output logic       audio_pwm
);

   logic [4:0] pwm_cnt;

   // Runs regardless of state so commands never restart the PWM frame.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 5'd1;
      end
   end

   assign audio_pwm = en & sq & (pwm_cnt < vol_q);

endmodule

// File: rtl/audio_tone_gen.sv
// audio_tone_gen: plays a table-selected square-wave tone from decoder commands.
//   clk, reset    clock, synchronous active-low reset
//   audio_en      command strobe
//   audio_sel     note index, 0 = stop
//   audio_vol     volume 0..31, 0 = stop
//   audio_pwm     PWM audio bit
//   audio_sample  signed sample, +vol / -vol while playing, else 0
//   playing       high in PLAY
module audio_tone_gen
   import audio_pkg::*;
#(
   parameter int unsigned DIV_SHIFT   = 0,
   parameter int unsigned HOLD_CYCLES = 0,
   parameter int unsigned HOLD_W      = 24
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       audio_en,
   input  logic [3:0]                 audio_sel,
   input  logic [4:0]                 audio_vol,
   output logic                       audio_pwm,
   output logic signed [SAMPLE_W-1:0] audio_sample,
   output logic                       playing
);

   localparam logic [HOLD_W-1:0] HOLD_LAST =
      HOLD_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

   audio_state_t      state;
   logic [3:0]        sel_q;
   logic [4:0]        vol_q;
   logic [NOTE_W-1:0] phase_cnt;
   logic              sq;
   logic [HOLD_W-1:0] hold_cnt;
   logic [NOTE_W-1:0] half;
   logic [SAMPLE_W-1:0] mag;

   assign half = half_period(sel_q, DIV_SHIFT);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         sel_q     <= '0;
         vol_q     <= '0;
         phase_cnt <= '0;
         sq        <= 1'b0;
         hold_cnt  <= '0;
      end else if (audio_en && (audio_sel == '0 || audio_vol == '0)) begin
         state     <= IDLE;
         sel_q     <= '0;
         vol_q     <= '0;
         phase_cnt <= '0;
         sq        <= 1'b0;
         hold_cnt  <= '0;
      end else if (audio_en && (state == IDLE || audio_sel != sel_q)) begin
         state     <= PLAY;
         sel_q     <= audio_sel;
         vol_q     <= audio_vol;
         phase_cnt <= '0;
         sq        <= 1'b1;
         hold_cnt  <= '0;
      end else if (state == PLAY) begin
         if (phase_cnt == half - NOTE_W'(1)) begin
            phase_cnt <= '0;
            sq        <= ~sq;
         end else begin
            phase_cnt <= phase_cnt + NOTE_W'(1);
         end

         // A same-note command (including a stalled strobe) only refreshes the
         // volume and the hold timer; the timeout below overrides the phase
         // update on the cycle it fires.
         if (audio_en) begin
            vol_q    <= audio_vol;
            hold_cnt <= '0;
         end else if (HOLD_CYCLES != 0) begin
            if (hold_cnt == HOLD_LAST) begin
               state     <= IDLE;
               sel_q     <= '0;
               vol_q     <= '0;
               phase_cnt <= '0;
               sq        <= 1'b0;
               hold_cnt  <= '0;
            end else begin
               hold_cnt <= hold_cnt + HOLD_W'(1);
            end
         end
      end
   end

   assign playing      = (state == PLAY);
   assign mag          = {1'b0, vol_q};
   assign audio_sample = !playing ? '0 : (sq ? mag : -mag);

   audio_pwm_mod u_pwm (
      .clk       (clk),
      .reset     (reset),
      .en        (playing),
      .sq        (sq),
      .vol_q     (vol_q),
      .audio_pwm (audio_pwm)
   );

endmodule
